triangle_tracker: RTL and testbench

- Receiver-side counterpart to the triangle wave source.
- Consumes a stream of N-bit samples, qualified by `ena`, that should form an ideal up/down triangle: 0 up to 2^N-1, then back down to 0.
- Recovers direction, flags turnarounds, measures period in samples and detects malformed steps.
- Sits downstream of the generator, or any sampled waveform, as a monitor/self-check block.

---
 rtl/triangle_pkg.sv | 14 +
 rtl/comparator_eq.sv | 12 +
 rtl/sat_counter.sv | 34 +++
 rtl/triangle_tracker.sv | 168 ++++++++++++++++
 tb/tb_triangle_tracker.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/triangle_pkg.sv
// Shared types and constants for the triangle-wave tracker.
package triangle_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME      = 2'd1,
    TRACK_UP   = 2'd2,
    TRACK_DOWN = 2'd3
  } tri_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/comparator_eq.sv
// Width-parameterised equality comparator.
module comparator_eq #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/sat_counter.sv
// Width-W up counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/triangle_tracker.sv
// Locks onto an ideal up/down triangle stream, flags turnarounds and bad steps,
// and measures the trough-to-trough period in accepted samples.
module triangle_tracker
  import triangle_pkg::*;
#(
  parameter int N        = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N-1:0]        sample,
  output logic                dir_up,
  output logic                locked,
  output logic                peak_pulse,
  output logic                trough_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                step_error
);

  localparam logic [N:0] ONE_EXT = {{N{1'b0}}, 1'b1};

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  tri_state_t          state_q, state_d;
  logic [N-1:0]        prev_q, prev_d;
  logic                have_trough_q, have_trough_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_up_q, dir_up_d;
  logic                locked_q, locked_d;
  logic                peak_q, peak_d;
  logic                trough_q, trough_d;
  logic                pvalid_q, pvalid_d;
  logic                err_q, err_d;
  logic                cnt_clr, cnt_en;
  logic [PERIOD_W-1:0] count;

  // Extra top bit keeps 2^N-1 -> 0 and 0 -> 2^N-1 from looking like legal steps.
  logic [N:0] prev_ext, samp_ext, prev_plus1, samp_plus1;
  logic       is_up, is_down;

  assign prev_ext   = {1'b0, prev_q};
  assign samp_ext   = {1'b0, sample};
  assign prev_plus1 = prev_ext + ONE_EXT;
  assign samp_plus1 = samp_ext + ONE_EXT;

  comparator_eq #(.W(N+1)) u_cmp_up (
    .a  (samp_ext),
    .b  (prev_plus1),
    .eq (is_up)
  );

  comparator_eq #(.W(N+1)) u_cmp_down (
    .a  (samp_plus1),
    .b  (prev_ext),
    .eq (is_down)
  );

  sat_counter #(.W(PERIOD_W)) u_count (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (count)
  );

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    have_trough_d = have_trough_q;
    period_d      = period_q;
    peak_d        = 1'b0;
    trough_d      = 1'b0;
    pvalid_d      = 1'b0;
    err_d         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    if (ena) begin
      prev_d = sample;
      case (state_q)
        IDLE: begin
          state_d       = PRIME;
          cnt_clr       = 1'b1;
          have_trough_d = 1'b0;
        end
        PRIME: begin
          if (is_up)        state_d = TRACK_UP;
          else if (is_down) state_d = TRACK_DOWN;
          else              err_d   = 1'b1;
        end
        TRACK_UP: begin
          cnt_en = 1'b1;
          if (is_down) begin
            state_d = TRACK_DOWN;
            peak_d  = 1'b1;
          end else if (!is_up) begin
            err_d = 1'b1;
          end
        end
        TRACK_DOWN: begin
          cnt_en = 1'b1;
          if (is_up) begin
            state_d  = TRACK_UP;
            trough_d = 1'b1;
            // The trough sample itself closes the period, hence the +1.
            if (have_trough_q) begin
              period_d = sat_inc(count);
              pvalid_d = 1'b1;
            end
            cnt_clr       = 1'b1;
            have_trough_d = 1'b1;
          end else if (!is_down) begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (err_d) begin
        state_d       = PRIME;
        cnt_clr       = 1'b1;
        have_trough_d = 1'b0;
      end
    end

    dir_up_d = (state_d == TRACK_UP) ? DIR_UP : DIR_DOWN;
    locked_d = (state_d == TRACK_UP) || (state_d == TRACK_DOWN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      have_trough_q <= 1'b0;
      period_q      <= '0;
      dir_up_q      <= 1'b0;
      locked_q      <= 1'b0;
      peak_q        <= 1'b0;
      trough_q      <= 1'b0;
      pvalid_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      have_trough_q <= have_trough_d;
      period_q      <= period_d;
      dir_up_q      <= dir_up_d;
      locked_q      <= locked_d;
      peak_q        <= peak_d;
      trough_q      <= trough_d;
      pvalid_q      <= pvalid_d;
      err_q         <= err_d;
    end
  end

  assign dir_up       = dir_up_q;
  assign locked       = locked_q;
  assign peak_pulse   = peak_q;
  assign trough_pulse = trough_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign step_error   = err_q;

endmodule

// File: tb/tb_triangle_tracker.sv
// Scoreboard bench for triangle_tracker (N=4); a second instance with PERIOD_W=4 shares the stimulus.
module tb_triangle_tracker;

  localparam int N = 4;
  localparam int S_IDLE = 0, S_PRIME = 1, S_UP = 2, S_DN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic [N-1:0] sample = '0;

  logic        a_dir, a_lock, a_peak, a_trough, a_pv, a_err;
  logic [15:0] a_period;
  logic        b_dir, b_lock, b_peak, b_trough, b_pv, b_err;
  logic [3:0]  b_period;

  triangle_tracker #(.N(N), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst_n), .ena(ena), .sample(sample),
    .dir_up(a_dir), .locked(a_lock), .peak_pulse(a_peak), .trough_pulse(a_trough),
    .period(a_period), .period_valid(a_pv), .step_error(a_err)
  );

  triangle_tracker #(.N(N), .PERIOD_W(4)) dut_sat (
    .clk(clk), .rst(rst_n), .ena(ena), .sample(sample),
    .dir_up(b_dir), .locked(b_lock), .peak_pulse(b_peak), .trough_pulse(b_trough),
    .period(b_period), .period_valid(b_pv), .step_error(b_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] main_v;
    logic [9:0]  sat_v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int m_state, m_prev, m_count, m_have, m_period;
  bit m_peak, m_trough, m_pv, m_err;

  task automatic model_step(input bit r, input bit e, input int s);
    bit up, dn;
    m_peak = 0; m_trough = 0; m_pv = 0; m_err = 0;
    if (!r) begin
      m_state = S_IDLE; m_prev = 0; m_count = 0; m_have = 0; m_period = 0;
    end else if (e) begin
      up = (s == m_prev + 1);
      dn = (s == m_prev - 1);
      case (m_state)
        S_IDLE: begin m_state = S_PRIME; m_count = 0; m_have = 0; end
        S_PRIME: begin
          if (up) m_state = S_UP;
          else if (dn) m_state = S_DN;
          else m_err = 1;
        end
        S_UP: begin
          if (up) m_count++;
          else if (dn) begin m_state = S_DN; m_peak = 1; m_count++; end
          else m_err = 1;
        end
        default: begin
          if (dn) m_count++;
          else if (up) begin
            m_state = S_UP; m_trough = 1;
            if (m_have != 0) begin
              m_period = (m_count + 1 > 65535) ? 65535 : m_count + 1;
              m_pv = 1;
            end
            m_count = 0; m_have = 1;
          end else m_err = 1;
        end
      endcase
      if (m_count > 65535) m_count = 65535;
      if (m_err) begin m_state = S_PRIME; m_count = 0; m_have = 0; end
      m_prev = s;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input int s);
    exp_t x;
    bit d, l;
    int p4;
    @(negedge clk);
    rst_n = r; ena = e; sample = s[N-1:0];
    model_step(r, e, s);
    d = (m_state == S_UP);
    l = (m_state == S_UP) || (m_state == S_DN);
    p4 = (m_period > 15) ? 15 : m_period;
    x.main_v = {d, l, m_peak, m_trough, m_pv, m_err, 16'(m_period)};
    x.sat_v  = {d, l, m_peak, m_trough, m_pv, m_err, 4'(p4)};
    exp_q.push_back(x);
  endtask

  bit gaps = 0;

  task automatic send(input int s);
    cycle(1, 1, s);
    if (gaps) cycle(1, 0, 10);
  endtask

  task automatic ramp(input int from, input int to);
    if (from <= to) for (int v = from; v <= to; v++) send(v);
    else            for (int v = from; v >= to; v--) send(v);
  endtask

  task automatic ideal_stream();
    send(0); ramp(1, 15); ramp(14, 0); ramp(1, 15); ramp(14, 0); send(1);
  endtask

  // Monitor: every cycle after stimulus the DUTs present a full output set
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t x;
      logic [21:0] got_a;
      logic [9:0]  got_b;
      x = exp_q.pop_front();
      got_a = {a_dir, a_lock, a_peak, a_trough, a_pv, a_err, a_period};
      got_b = {b_dir, b_lock, b_peak, b_trough, b_pv, b_err, b_period};
      checks++;
      if (got_a !== x.main_v) begin
        errors++;
        $display("FAIL cyc%0d main {dir,lock,peak,trough,pv,err,period} got %h want %h",
                 cyc, got_a, x.main_v);
      end
      checks++;
      if (got_b !== x.sat_v) begin
        errors++;
        $display("FAIL cyc%0d sat4 {dir,lock,peak,trough,pv,err,period} got %h want %h",
                 cyc, got_b, x.sat_v);
      end
    end
  end

  initial begin
    // Reset state
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    // Ideal stream, continuous
    ideal_stream();
    // Reset (overriding ena) then the same stream with gaps
    cycle(0, 1, 3);
    gaps = 1;
    ideal_stream();
    gaps = 0;
    // Rising lock broken by 15 -> 0, then re-lock on 1
    ramp(2, 15); send(0); send(1);
    // Full cycle without prior trough, then repeated 7 while falling
    ramp(2, 15); ramp(14, 0); send(1);
    ramp(2, 15); ramp(14, 7); send(7);
    send(6); ramp(5, 0); send(1);
    // Reset mid-waveform with ena high, then restart
    ramp(2, 4);
    cycle(0, 1, 5);
    send(6); send(7); send(8);
    cycle(1, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
